reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard_sb_counter.sv | 34 +++
 rtl/reg_scoreboard.sv | 93 +++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Processor-wide shared constants: register-file index width and the
// default depth of the scoreboard's pending-write counters.
package reg_scoreboard_pkg;

  // Register index width shared with the register file.
  localparam int REG_IDX_W = 4;
  localparam int NUM_ARCH_REGS = 1 << REG_IDX_W;

  // Default width of each per-register pending-write counter.
  localparam int SB_CNT_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bus between the pipeline and the register scoreboard.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_INDEX_WIDTH = REG_IDX_W,
  parameter int CNT_WIDTH       = SB_CNT_W
);
  logic                                issue_valid;
  logic                                issue_ready;
  logic [REG_INDEX_WIDTH-1:0]          sr1_ind;
  logic [REG_INDEX_WIDTH-1:0]          sr2_ind;
  logic                                sr1_used;
  logic                                sr2_used;
  logic [REG_INDEX_WIDTH-1:0]          dr_ind;
  logic                                dr_used;
  logic                                wb_valid;
  logic [REG_INDEX_WIDTH-1:0]          wb_ind;
  logic                                flush;
  logic [(1<<REG_INDEX_WIDTH)-1:0]     busy_vec;
  logic [REG_INDEX_WIDTH+CNT_WIDTH-1:0] inflight;
  logic                                wb_error;

  // Pipeline side: presents instructions and writebacks.
  modport master (
    output issue_valid, sr1_ind, sr2_ind, sr1_used, sr2_used,
           dr_ind, dr_used, wb_valid, wb_ind, flush,
    input  issue_ready, busy_vec, inflight, wb_error
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, sr1_ind, sr2_ind, sr1_used, sr2_used,
           dr_ind, dr_used, wb_valid, wb_ind, flush,
    output issue_ready, busy_vec, inflight, wb_error
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Single saturating up/down pending-write counter for one register.
module sb_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_underflow
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_count;

  // Clear wins; simultaneous inc and dec cancel; saturate at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count     = r_count;
  // A lone decrement of an empty counter is a writeback with nothing pending.
  assign o_underflow = i_dec && !i_inc && !i_clr && (r_count == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register,
// stalls issue on RAW hazards and counter saturation, flags stray writebacks.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int REG_INDEX_WIDTH = REG_IDX_W,
  parameter int CNT_WIDTH       = SB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  reg_scoreboard_if.slave   sb
);
  localparam int NUM_REGS = 1 << REG_INDEX_WIDTH;
  localparam int INF_W    = REG_INDEX_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  w_inc;
  logic [NUM_REGS-1:0]  w_dec;
  logic [NUM_REGS-1:0]  w_uf;
  logic [NUM_REGS-1:0]  w_busy;
  logic                 w_ready;
  logic                 w_fire;
  logic                 w_same;
  logic                 w_up;
  logic                 w_dn;
  logic [INF_W-1:0]     r_inflight;
  logic                 r_wb_error;

  // Hazard check against registered state only; no writeback bypass.
  always_comb begin
    w_ready = 1'b1;
    if (sb.flush)                                  w_ready = 1'b0;
    if (sb.sr1_used && w_busy[sb.sr1_ind])         w_ready = 1'b0;
    if (sb.sr2_used && w_busy[sb.sr2_ind])         w_ready = 1'b0;
    if (sb.dr_used && (w_cnt[sb.dr_ind] == CNT_MAX)) w_ready = 1'b0;
  end

  assign w_fire = sb.issue_valid && w_ready;

  // Net effect on the total: an issue and writeback to the same register cancel.
  assign w_same = w_fire && sb.dr_used && sb.wb_valid && (sb.dr_ind == sb.wb_ind);
  assign w_up   = w_fire && sb.dr_used && !w_same;
  assign w_dn   = sb.wb_valid && !w_same && (w_cnt[sb.wb_ind] != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
      assign w_inc[gi] = w_fire && sb.dr_used && (sb.dr_ind == REG_INDEX_WIDTH'(gi));
      assign w_dec[gi] = sb.wb_valid && (sb.wb_ind == REG_INDEX_WIDTH'(gi));

      sb_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk         (clk),
        .rst         (reset),
        .i_inc       (w_inc[gi]),
        .i_dec       (w_dec[gi]),
        .i_clr       (sb.flush),
        .o_count     (w_cnt[gi]),
        .o_underflow (w_uf[gi])
      );

      assign w_busy[gi] = (w_cnt[gi] != '0);
    end
  endgenerate

  // Running total of pending writes, updated on the same edge as the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else if (sb.flush) begin
      r_inflight <= '0;
    end else if (w_up && !w_dn) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (w_dn && !w_up) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Sticky stray-writeback flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_error <= 1'b0;
    end else if (|w_uf) begin
      r_wb_error <= 1'b1;
    end
  end

  assign sb.issue_ready = w_ready;
  assign sb.busy_vec    = w_busy;
  assign sb.inflight    = r_inflight;
  assign sb.wb_error    = r_wb_error;

endmodule
